// File: rtl/alu_stage_pkg.sv
// Shared core package: ALU operation encodings and datapath widths.
package alu_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  // Encodings 10..15 are unassigned and yield a zero result.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

endpackage

// File: rtl/alu_stage_bitwise.sv
// Logic/shift unit: bitwise ops and shifts on a 32-bit operand pair.
// Ports:
//   op1_i, op2_i : source operands (only op2_i[4:0] is used as shift amount)
//   arith_i      : sign-fill select for the right shift
//   xor_o/or_o/and_o : bitwise results
//   sll_o        : logical left shift
//   sr_o         : 33-bit right shift; bits [31:0] are the SRL/SRA result
module alu_stage_bitwise
  import alu_stage_pkg::*;
(
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            arith_i,
  output logic [XLEN-1:0] xor_o,
  output logic [XLEN-1:0] or_o,
  output logic [XLEN-1:0] and_o,
  output logic [XLEN-1:0] sll_o,
  output logic [XLEN:0]   sr_o
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = op2_i[SHAMT_W-1:0];

  assign xor_o = op1_i ^ op2_i;
  assign or_o  = op1_i | op2_i;
  assign and_o = op1_i & op2_i;
  assign sll_o = op1_i << shamt;

  // One signed shifter serves both SRL and SRA: the extra top bit is the fill value.
  assign sr_o = (XLEN+1)'($signed({arith_i & op1_i[XLEN-1], op1_i}) >>> shamt);

endmodule

// File: rtl/alu_stage.sv
// Single-entry ALU pipeline stage with valid/ready handshake and 1-cycle latency.
// Ports:
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_flush           : drop the held result and the operation offered this cycle
//   i_valid / o_ready : upstream handshake (o_ready is combinational)
//   i_op, i_op1, i_op2, i_rd : operation, operands, destination tag
//   o_valid / i_ready : downstream handshake
//   o_result, o_rd    : registered result and tag
module alu_stage
  import alu_stage_pkg::*;
#(
  parameter int unsigned RD_W = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  alu_op_t         i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [RD_W-1:0] i_rd,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [RD_W-1:0] o_rd
);

  logic [XLEN-1:0] xor_w, or_w, and_w, sll_w;
  logic [XLEN:0]   sr_w;
  logic            unused_sr_msb;

  logic [XLEN-1:0] add_w;
  logic [XLEN:0]   sub_w;
  logic            lt_u, lt_s;
  logic [XLEN-1:0] alu_res;
  logic            accept;

  logic            valid_q,  valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [RD_W-1:0] rd_q,     rd_d;

  alu_stage_bitwise u_bitwise (
    .op1_i   (i_op1),
    .op2_i   (i_op2),
    .arith_i (i_op == ALU_SRA),
    .xor_o   (xor_w),
    .or_o    (or_w),
    .and_o   (and_w),
    .sll_o   (sll_w),
    .sr_o    (sr_w)
  );

  assign unused_sr_msb = sr_w[XLEN];

  // Shared 33-bit subtract: low 32 bits give SUB, carry-out gives unsigned compare.
  assign add_w = i_op1 + i_op2;
  assign sub_w = {1'b0, i_op1} + {1'b0, ~i_op2} + (XLEN+1)'(1);
  assign lt_u  = ~sub_w[XLEN];
  // Differing signs decide signed order directly; equal signs cannot overflow.
  assign lt_s  = (i_op1[XLEN-1] ^ i_op2[XLEN-1]) ? i_op1[XLEN-1] : sub_w[XLEN-1];

  // Result mux.
  always_comb begin
    alu_res = '0;
    case (i_op)
      ALU_ADD:  alu_res = add_w;
      ALU_SUB:  alu_res = sub_w[XLEN-1:0];
      ALU_XOR:  alu_res = xor_w;
      ALU_OR:   alu_res = or_w;
      ALU_AND:  alu_res = and_w;
      ALU_SLL:  alu_res = sll_w;
      ALU_SRL:  alu_res = sr_w[XLEN-1:0];
      ALU_SRA:  alu_res = sr_w[XLEN-1:0];
      ALU_SLT:  alu_res = XLEN'(lt_s);
      ALU_SLTU: alu_res = XLEN'(lt_u);
      default:  alu_res = '0;
    endcase
  end

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready && !i_flush;

  // Next-state: flush beats accept; a drain with no accept empties the stage.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      rd_d     = i_rd;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_rd     = rd_q;

endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage: directed corner cases followed by random traffic.
module tb_alu_stage;
  import alu_stage_pkg::*;

  localparam int unsigned RD_W = 5;

  logic            clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_flush = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  alu_op_t         i_op = ALU_ADD;
  logic [31:0]     i_op1 = '0;
  logic [31:0]     i_op2 = '0;
  logic [RD_W-1:0] i_rd = '0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [31:0]     o_result;
  logic [RD_W-1:0] o_rd;

  always #5 clk = ~clk;

  alu_stage #(.RD_W(RD_W)) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_rd     (i_rd),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_rd     (o_rd)
  );

  typedef struct {
    logic [31:0]     res;
    logic [RD_W-1:0] rd;
  } exp_t;

  exp_t            sb_q[$];
  int unsigned     n_vec = 0;
  int unsigned     n_err = 0;
  logic [31:0]     last_res = '0;
  logic [RD_W-1:0] last_rd = '0;

  // Reference ALU straight from the operation definitions.
  function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return 32'($signed(a) >>> sh);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and update the model after the edge.
  task automatic cycle(input logic v, input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [RD_W-1:0] rd, input logic rdy, input logic fl, input logic rst);
    logic        acc;
    logic [31:0] e;
    i_valid = v; i_op = op; i_op1 = a; i_op2 = b; i_rd = rd;
    i_ready = rdy; i_flush = fl; i_reset = rst;
    acc = v && (sb_q.size() == 0 || rdy) && !fl;
    e   = ref_alu(op, a, b);
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
      last_res = '0;
      last_rd  = '0;
    end else if (fl) begin
      sb_q.delete();
    end else if (acc) begin
      sb_q.push_back('{e, rd});
      last_res = e;
      last_rd  = rd;
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: checks presented outputs mid-cycle and retires transfers from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    check("o_ready", 32'(o_ready), 32'(sb_q.size() == 0 || i_ready));
    check("o_valid", 32'(o_valid), 32'(sb_q.size() != 0));
    check("o_result_hold", o_result, last_res);
    check("o_rd_hold", 32'(o_rd), 32'(last_rd));
    if (o_valid && i_ready && !i_flush && !i_reset) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'(o_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", o_result, e.res);
        check("sb_rd", 32'(o_rd), 32'(e.rd));
      end
    end
  end

  initial begin
    cycle(1'b1, ALU_ADD, 32'h1234, 32'h1, 5'd7, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, ALU_ADD, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_ready", 32'(o_ready), 32'd1);

    // ADD wraps to zero, tag passes through.
    cycle(1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0);
    check("add_wrap_valid", 32'(o_valid), 32'd1);
    check("add_wrap_result", o_result, 32'h0);
    check("add_wrap_rd", 32'(o_rd), 32'd3);

    // Shifts use only op2[4:0].
    cycle(1'b1, ALU_SRA, 32'h8000_0000, 32'h24, 5'd4, 1'b1, 1'b0, 1'b0);
    check("sra", o_result, 32'hF800_0000);
    cycle(1'b1, ALU_SRL, 32'h8000_0000, 32'h24, 5'd5, 1'b1, 1'b0, 1'b0);
    check("srl", o_result, 32'h0800_0000);

    cycle(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd6, 1'b1, 1'b0, 1'b0);
    check("slt", o_result, 32'd1);
    cycle(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("sltu", o_result, 32'd0);

    // Stall for three cycles, then drain and accept in the same cycle.
    cycle(1'b1, ALU_SUB, 32'd10, 32'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd10, 1'b0, 1'b0, 1'b0);
      check("stall_ready", 32'(o_ready), 32'd0);
      check("stall_result", o_result, 32'd7);
      check("stall_rd", 32'(o_rd), 32'd9);
    end
    cycle(1'b1, ALU_OR, 32'hF000_0000, 32'h0000_000F, 5'd11, 1'b1, 1'b0, 1'b0);
    check("nobubble_valid", 32'(o_valid), 32'd1);
    check("nobubble_result", o_result, 32'hF000_000F);
    check("nobubble_rd", 32'(o_rd), 32'd11);

    // Flush with a held result and a new offer: both dropped.
    cycle(1'b1, ALU_AND, 32'hFFFF_FFFF, 32'h1234_5678, 5'd12, 1'b0, 1'b1, 1'b0);
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_result", o_result, 32'hF000_000F);

    // Unassigned encoding still completes with zero.
    cycle(1'b1, alu_op_t'(4'd13), 32'hDEAD_BEEF, 32'h1, 5'd13, 1'b1, 1'b0, 1'b0);
    check("badop_valid", 32'(o_valid), 32'd1);
    check("badop_result", o_result, 32'd0);

    // Reset during a stall.
    cycle(1'b1, ALU_ADD, 32'd5, 32'd6, 5'd14, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, ALU_ADD, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, ALU_SUB, 32'd9, 32'd1, 5'd15, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_rd", 32'(o_rd), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            alu_op_t'(4'($urandom_range(0, 15))),
            rand_word(), rand_word(),
            RD_W'($urandom),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 63) == 0));
    end

    cycle(1'b0, ALU_ADD, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have parameter RD_W, default 5, destination register tag width.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_flush  input  1  discard the held result (branch/trap redirect).
REQ-005 SHALL have port i_valid  input  1  upstream operands valid.
REQ-006 SHALL have port o_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port i_op  input  alu_op_t (4)  operation select.
REQ-008 SHALL have ports i_op1, i_op2  input  32 each  source operands.
REQ-009 SHALL have port i_rd  input  RD_W  destination tag, passed through.
REQ-010 SHALL have port o_valid  output  1  result register holds a live result.
REQ-011 SHALL have port i_ready  input  1  downstream accepts result this cycle.
REQ-012 SHALL have ports o_result  output  32 and o_rd  output  RD_W, the registered result and tag.

Function
REQ-013 SHALL support operations ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU; other encodings SHALL produce result 0 and still complete the handshake.
REQ-014 SHALL take XOR/OR/AND/SLL results and SRL/SRA from the logic/shift unit, using bits [31:0] of its 33-bit right-shift output, with the arithmetic-shift select asserted only for SRA.
REQ-015 SHALL use only op2[4:0] as shift amount; op2[31:5] SHALL be ignored for shifts.
REQ-016 SHALL compute ADD/SUB modulo 2^32; SUB as op1 + ~op2 + 1.
REQ-017 SHALL compute SLT as signed op1 < op2 and SLTU as unsigned op1 < op2, result 32'd1 or 32'd0, using one 33-bit subtraction shared with SUB.
REQ-018 SHALL have latency exactly 1 cycle: an operation accepted on edge N is presented on o_result/o_rd with o_valid=1 after edge N.
REQ-019 SHALL drive o_ready = !o_valid || i_ready, combinationally, with no dependency on i_valid.
REQ-020 SHALL accept (capture result and i_rd, set o_valid) when i_valid && o_ready && !i_flush.
REQ-021 SHALL clear o_valid when o_valid && i_ready and no new accept occurs in the same cycle.
REQ-022 SHALL, on a simultaneous drain and accept, replace the result without a bubble (back-to-back throughput 1/cycle).
REQ-023 SHALL hold o_result and o_rd stable while o_valid && !i_ready (stall).
REQ-024 SHALL give i_flush priority over accept and hold: next cycle o_valid=0, and the operation offered in the flush cycle is dropped.
REQ-025 SHALL leave o_result/o_rd unchanged when no accept occurs (no update when o_valid falls).

Reset
REQ-026 SHALL, with i_reset high at an edge, set o_valid=0, o_result=0, o_rd=0, regardless of i_valid, i_flush, i_ready.
REQ-027 SHALL give reset priority over flush and accept; an operation in flight when reset asserts SHALL be lost.
REQ-028 SHALL keep o_ready=1 during and immediately after reset (follows from o_valid=0).

Structure
REQ-029 SHALL take alu_op_t (enum, 4 bits) and its encodings from the shared core package; no local op constants.
REQ-030 SHALL instantiate the existing logic/shift unit (bitwise) as its single sub-module for XOR/OR/AND/SLL/SRL/SRA.
REQ-031 SHALL keep the adder/comparator and result mux local; one result register, one valid flop, one tag register.

Verification
REQ-032 SHALL verify: ADD 0xFFFFFFFF+0x00000001, rd=3 -> next cycle o_valid=1, o_result=0x00000000, o_rd=3.
REQ-033 SHALL verify: SRA 0x80000000 by op2=0x00000024 (amount 4) -> 0xF8000000; SRL same operands -> 0x08000000.
REQ-034 SHALL verify: SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU same operands -> 0.
REQ-035 SHALL verify: result valid with i_ready=0 for 3 cycles -> o_ready=0, o_result/o_rd held; i_ready=1 with new i_valid -> next op delivered with no bubble.
REQ-036 SHALL verify: i_flush with i_valid=1 and o_valid=1 -> next cycle o_valid=0, no capture.
REQ-037 SHALL verify: i_reset mid-stall with o_valid=1 -> next cycle o_valid=0, o_result=0, o_rd=0, o_ready=1.
